// File: rtl/fuse_pkg.sv
// Shared types, default sizing and parity helper for the eFuse auto-load controller.
package fuse_pkg;

  localparam int unsigned FUSE_WORD_NUM  = 8;
  localparam int unsigned FUSE_ADDR_W    = 3;
  localparam int unsigned FUSE_DATA_W    = 16;
  localparam int unsigned FUSE_RD_CYC    = 4;
  localparam int unsigned FUSE_MAX_RETRY = 2;
  localparam int unsigned PAR_MAX_W      = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } fuse_state_e;

  // Zero-extension leaves the XOR reduction unchanged, so one width serves all callers.
  function automatic logic odd_par_ok(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/fuse_load_ctrl_if.sv
// Fuse macro read port and shadow register write port seen by the load controller.
interface fuse_load_ctrl_if
  import fuse_pkg::*;
#(
  parameter int unsigned ADDR_W = FUSE_ADDR_W,
  parameter int unsigned DATA_W = FUSE_DATA_W
);

  logic [DATA_W-1:0] fuse_dout;
  logic              fuse_par;
  logic [ADDR_W-1:0] fuse_addr;
  logic              fuse_rden;
  logic              shd_we;
  logic [ADDR_W-1:0] shd_addr;
  logic [DATA_W-1:0] shd_wdata;

  modport master (
    input  fuse_dout, fuse_par,
    output fuse_addr, fuse_rden, shd_we, shd_addr, shd_wdata
  );

  modport slave (
    output fuse_dout, fuse_par,
    input  fuse_addr, fuse_rden, shd_we, shd_addr, shd_wdata
  );

endinterface

// File: rtl/fuse_par_chk.sv
// Combinational odd-parity checker over a fuse word and its parity bit.
module fuse_par_chk
  import fuse_pkg::*;
#(
  parameter int unsigned DATA_W = FUSE_DATA_W
) (
  input  logic [DATA_W:0] i_vec,
  output logic            o_ok_c
);

  assign o_ok_c = odd_par_ok(PAR_MAX_W'(i_vec));

endmodule

// File: rtl/fuse_load_ctrl.sv
// eFuse auto-load sequencer: reads each fuse word, checks parity with bounded
// retries and copies it into the shadow registers while holding the clock open.
module fuse_load_ctrl
  import fuse_pkg::*;
#(
  parameter int unsigned WORD_NUM  = FUSE_WORD_NUM,
  parameter int unsigned ADDR_W    = FUSE_ADDR_W,
  parameter int unsigned DATA_W    = FUSE_DATA_W,
  parameter int unsigned RD_CYC    = FUSE_RD_CYC,
  parameter int unsigned MAX_RETRY = FUSE_MAX_RETRY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic                    sw_reload,
  fuse_load_ctrl_if.master        bus,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err,
  output logic                    clk_hold
);

  localparam int unsigned CYC_W = (RD_CYC > 1) ? $clog2(RD_CYC) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  fuse_state_e       r_state, w_state_nxt;
  logic              r_start_d;
  logic              r_auto_used, w_auto_used_nxt;
  logic [ADDR_W-1:0] r_word, w_word_nxt;
  logic [RTY_W-1:0]  r_retry, w_retry_nxt;
  logic [CYC_W-1:0]  r_cyc, w_cyc_nxt;
  logic              r_err, w_err_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;

  logic              r_busy, r_done, r_rden, r_we;
  logic [ADDR_W-1:0] r_addr, r_shd_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_par_ok, w_idle_or_done, w_start_edge, w_auto_acc, w_go;

  fuse_par_chk #(.DATA_W(DATA_W)) u_par_chk (
    .i_vec  ({bus.fuse_dout, bus.fuse_par}),
    .o_ok_c (w_par_ok)
  );

  // Triggers are only accepted while no load is in flight.
  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_edge   = load_start & ~r_start_d;
  assign w_auto_acc     = w_start_edge & ~r_auto_used & w_idle_or_done;
  assign w_go           = w_auto_acc | (sw_reload & w_idle_or_done);

  always_comb begin
    w_state_nxt     = r_state;
    w_word_nxt      = r_word;
    w_retry_nxt     = r_retry;
    w_cyc_nxt       = r_cyc;
    w_err_nxt       = r_err;
    w_wdata_nxt     = '0;
    w_auto_used_nxt = r_auto_used | w_auto_acc;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_go) begin
          w_state_nxt = ST_RD;
          w_word_nxt  = '0;
          w_retry_nxt = '0;
          w_cyc_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      ST_RD: begin
        if (r_cyc == CYC_W'(RD_CYC - 1)) begin
          w_cyc_nxt   = '0;
          w_state_nxt = ST_CAP;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_CAP: begin
        if (w_par_ok) begin
          w_wdata_nxt = bus.fuse_dout;
          w_state_nxt = ST_WR;
        end else if (r_retry < RTY_W'(MAX_RETRY)) begin
          w_retry_nxt = r_retry + RTY_W'(1);
          w_state_nxt = ST_RD;
        end else begin
          // Retries exhausted: flag it and shadow a known-zero word.
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        w_retry_nxt = '0;
        if (r_word == ADDR_W'(WORD_NUM - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_word_nxt  = r_word + ADDR_W'(1);
          w_state_nxt = ST_RD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs all load from the next-state view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_start_d   <= 1'b0;
      r_auto_used <= 1'b0;
      r_word      <= '0;
      r_retry     <= '0;
      r_cyc       <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rden      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_shd_addr  <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_d   <= load_start;
      r_auto_used <= w_auto_used_nxt;
      r_word      <= w_word_nxt;
      r_retry     <= w_retry_nxt;
      r_cyc       <= w_cyc_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= (w_state_nxt == ST_RD) || (w_state_nxt == ST_CAP) ||
                     (w_state_nxt == ST_WR);
      r_done      <= (w_state_nxt == ST_DONE);
      r_rden      <= (w_state_nxt == ST_RD);
      r_we        <= (w_state_nxt == ST_WR);
      r_addr      <= w_word_nxt;
      r_shd_addr  <= (w_state_nxt == ST_WR) ? w_word_nxt : '0;
      r_wdata     <= w_wdata_nxt;
    end
  end

  assign bus.fuse_addr = r_addr;
  assign bus.fuse_rden = r_rden;
  assign bus.shd_we    = r_we;
  assign bus.shd_addr  = r_shd_addr;
  assign bus.shd_wdata = r_wdata;
  assign load_busy     = r_busy;
  assign load_done     = r_done;
  assign load_err      = r_err;
  assign clk_hold      = r_busy;

endmodule

// File: tb/tb_fuse_load_ctrl.sv
// Directed bench for fuse_load_ctrl with a behavioural fuse macro and shadow write log.
`timescale 1ns/1ps
module tb_fuse_load_ctrl;
  import fuse_pkg::*;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0;
  logic sw_reload = 1'b0;
  logic load_busy, load_done, load_err, clk_hold;

  fuse_load_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fuse_load_ctrl #(
    .WORD_NUM(8), .ADDR_W(AW), .DATA_W(DW), .RD_CYC(4), .MAX_RETRY(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .sw_reload  (sw_reload),
    .bus        (bus),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .clk_hold   (clk_hold)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_val(input int i);
    return DW'(32'h1357 + i * 32'h2111);
  endfunction

  // Fuse macro model and shadow write log
  int err_word  = -1;
  int err_reads = 0;
  int rdcnt [8];
  logic rden_q = 1'b0;
  int wr_cnt = 0;
  logic [AW-1:0] wr_addr [16];
  logic [DW-1:0] wr_data [16];
  int hold_bad = 0;

  always @(negedge clk) begin : fuse_model
    int a;
    if (clk_hold !== load_busy) hold_bad++;
    if (bus.fuse_rden && !rden_q) begin
      a = int'(bus.fuse_addr);
      rdcnt[a]++;
      bus.fuse_dout = word_val(a);
      bus.fuse_par  = ~^word_val(a);
      if (a == err_word && rdcnt[a] <= err_reads) bus.fuse_par = ^word_val(a);
    end
    rden_q = bus.fuse_rden;
    if (bus.shd_we) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = bus.shd_addr;
        wr_data[wr_cnt] = bus.shd_wdata;
      end
      wr_cnt++;
    end
  end

  task automatic clear_log();
    wr_cnt = 0;
    foreach (rdcnt[i]) rdcnt[i] = 0;
  endtask

  // Counts edges after the trigger edge until load_done; optional sw_reload pulse mid-load.
  task automatic wait_done(input int pulse_at, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      sw_reload = (n == pulse_at);
    end while (!load_done && n < 300);
    sw_reload = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int zero_w);
    logic [DW-1:0] exp;
    check_eq({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp = (i == zero_w) ? '0 : word_val(i);
      check_eq($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
      check_eq($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(exp));
    end
  endtask

  task automatic pulse_sw();
    @(negedge clk); sw_reload = 1'b1;
    @(posedge clk); #1; sw_reload = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    bus.fuse_dout = '0;
    bus.fuse_par  = 1'b0;
    #12;
    check_eq("rst_outs", {16'd0, load_busy, load_done, load_err, clk_hold,
                          bus.fuse_rden, bus.shd_we, bus.fuse_addr, bus.shd_addr, 4'd0},
             32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(3);
    check_eq("idle_busy", 32'(load_busy), 32'd0);

    // 1: error-free auto load
    clear_log();
    @(negedge clk); load_start = 1'b1;
    @(posedge clk); #1;
    check_eq("t1_busy", 32'(load_busy), 32'd1);
    wait_done(-1, n);
    check_eq("t1_latency", 32'(n), 32'd48);
    check_eq("t1_err", 32'(load_err), 32'd0);
    check_writes("t1", -1);

    // 2: single parity error recovered on re-read
    clear_log(); err_word = 3; err_reads = 1;
    pulse_sw();
    wait_done(-1, n);
    check_eq("t2_latency", 32'(n), 32'd53);
    check_eq("t2_reads3", 32'(rdcnt[3]), 32'd2);
    check_eq("t2_err", 32'(load_err), 32'd0);
    check_writes("t2", -1);

    // 3: persistent parity error
    clear_log(); err_word = 5; err_reads = 99;
    pulse_sw();
    wait_done(-1, n);
    check_eq("t3_latency", 32'(n), 32'd58);
    check_eq("t3_reads5", 32'(rdcnt[5]), 32'd3);
    check_eq("t3_reads4", 32'(rdcnt[4]), 32'd1);
    check_eq("t3_err", 32'(load_err), 32'd1);
    check_writes("t3", 5);
    idle_cycles(5);
    check_eq("t3_err_sticky", 32'(load_err), 32'd1);
    err_word = -1;

    // 4: trigger filtering
    clear_log();
    @(negedge clk); load_start = 1'b0;
    idle_cycles(3);
    @(negedge clk); load_start = 1'b1;
    idle_cycles(12);
    check_eq("t4_edge_busy", 32'(load_busy), 32'd0);
    check_eq("t4_edge_done", 32'(load_done), 32'd1);
    check_eq("t4_edge_wr", 32'(wr_cnt), 32'd0);
    pulse_sw();
    check_eq("t4_sw_busy", 32'(load_busy), 32'd1);
    check_eq("t4_sw_done_clr", 32'(load_done), 32'd0);
    check_eq("t4_sw_err_clr", 32'(load_err), 32'd0);
    wait_done(10, n);
    check_eq("t4_latency", 32'(n), 32'd48);
    check_eq("t4_wr_cnt", 32'(wr_cnt), 32'd8);

    // 5: reset mid-load
    clear_log();
    pulse_sw();
    n = 0;
    while (!(bus.fuse_addr == 3'd4 && bus.fuse_rden) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_eq("t5_reach_w4", 32'(n < 100), 32'd1);
    #2; rst_n = 1'b0; load_start = 1'b0;
    #1;
    check_eq("t5_rst_outs", {16'd0, load_busy, load_done, load_err, clk_hold,
                             bus.fuse_rden, bus.shd_we, bus.fuse_addr, bus.shd_addr, 4'd0},
             32'd0);
    check_eq("t5_rst_wdata", 32'(bus.shd_wdata), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(3);
    check_eq("t5_post_idle", 32'(load_busy), 32'd0);
    clear_log();
    @(negedge clk); load_start = 1'b1;
    @(posedge clk); #1;
    wait_done(-1, n);
    check_eq("t5_latency", 32'(n), 32'd48);
    check_writes("t5", -1);

    // 6: simultaneous auto edge and sw_reload
    @(negedge clk); rst_n = 1'b0; load_start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(2);
    clear_log();
    @(negedge clk); load_start = 1'b1; sw_reload = 1'b1;
    @(posedge clk); #1; sw_reload = 1'b0;
    wait_done(-1, n);
    check_eq("t6_latency", 32'(n), 32'd48);
    idle_cycles(20);
    check_eq("t6_one_load", 32'(wr_cnt), 32'd8);
    @(negedge clk); load_start = 1'b0;
    idle_cycles(2);
    @(negedge clk); load_start = 1'b1;
    idle_cycles(10);
    check_eq("t6_auto_used", 32'(load_busy), 32'd0);
    check_eq("t6_wr_after", 32'(wr_cnt), 32'd8);
    check_eq("clk_hold_track", 32'(hold_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fuse_load_ctrl.md
Name: fuse_load_ctrl

Overview:
Sequences the automatic eFuse load that follows clock-gating start-up.
- On a rising edge of load_start, or a software reload pulse, reads WORD_NUM words from the eFuse macro, checks each word's odd parity and writes it into the shadow register file.
- Holds the system clock open (clk_hold) while loading; sits between the clock/reset generator and the fuse macro/shadow registers.

Parameters:
WORD_NUM, 8, number of fuse words loaded per sequence
ADDR_W, 3, fuse/shadow address width (2**ADDR_W >= WORD_NUM)
DATA_W, 16, fuse word width
RD_CYC, 4, fuse_rden pulse width in clk cycles (>=1)
MAX_RETRY, 2, re-reads allowed per word on parity error

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
load_start  in  1  auto-load request level; rising edge triggers a load
sw_reload  in  1  single-cycle software reload request
fuse_dout  in  DATA_W  fuse macro read data
fuse_par  in  1  fuse macro parity bit (odd parity over fuse_dout and fuse_par)
fuse_addr  out  ADDR_W  fuse word address
fuse_rden  out  1  fuse read strobe
shd_we  out  1  shadow register write enable, one cycle per word
shd_addr  out  ADDR_W  shadow write address
shd_wdata  out  DATA_W  shadow write data
load_busy  out  1  load in progress
load_done  out  1  level; last load completed
load_err  out  1  sticky; a word exhausted its retries in the last load
clk_hold  out  1  request to keep clock open (= load_busy)

Behaviour:
- Reset values:
  - All outputs 0, FSM IDLE.
  - Word, retry and RD_CYC counters 0.
  - start_d (registered load_start) 0.
  - auto_used flag 0.
- Triggers:
  - start_edge = load_start & ~start_d.
  - Auto trigger = start_edge & ~auto_used; it sets auto_used, so at most one auto load per reset.
  - sw_reload accepted only in IDLE or DONE; ignored while busy.
  - Simultaneous auto trigger and sw_reload start a single load and still set auto_used.
- Load start clears load_done and load_err, zeroes the word and retry counters, and enters RD.
- FSM states: IDLE, RD, CAP, WR, DONE.
  - RD:
    - fuse_rden=1, fuse_addr=word counter, for exactly RD_CYC cycles (cycle counter 0..RD_CYC-1), then CAP.
  - CAP (fuse_rden=0):
    - Sample fuse_dout/fuse_par; ok = ^{fuse_dout,fuse_par} == 1.
    - If ok, go to WR with the sampled data.
    - If not ok and retry < MAX_RETRY, increment retry and go back to RD on the same address.
    - If not ok and retries are exhausted, set load_err and go to WR with data forced to 0.
  - WR:
    - shd_we=1 for one cycle; shd_addr = word counter, shd_wdata = captured or zero data; retry is cleared.
    - If word == WORD_NUM-1, go to DONE; otherwise increment word and go to RD.
  - DONE:
    - load_done=1, load_busy=0.
    - Stays in DONE until an accepted sw_reload; DONE is never left on its own.
- Timing:
  - load_busy=1 from the cycle after trigger acceptance through the WR of the last word.
  - Error-free latency: WORD_NUM*(RD_CYC+2) cycles from the trigger cycle to the first load_done cycle (48 at defaults).
  - Each retry adds RD_CYC+1 cycles.
- Counters saturate within their ranges; the word counter never wraps past WORD_NUM-1.
- A load_start deassert/reassert while busy does not restart the load; start_d still tracks.
- rst_n assertion mid-load aborts immediately:
  - All outputs return to reset values; the shadow contents are left as written.
  - auto_used is cleared, so the next rising edge of load_start reloads.
- Outputs are registered, except clk_hold, which equals load_busy combinationally.

Decomposition:
- Shared package fuse_pkg holds:
  - the FSM state encoding (3-bit typedef);
  - defaults WORD_NUM, DATA_W, RD_CYC, MAX_RETRY;
  - the parity function.
- One sub-module, fuse_par_chk: combinational odd-parity checker, DATA_W+1 bits in, ok out.
- Edge detect and FSM stay in the top.

Test Plan:
1. Error-free auto load:
   - Stimulus: all 8 words with correct parity, load_start 0->1.
   - Response: 8 shd_we pulses at addr 0..7 with matching data; load_done rises 48 cycles after the trigger; load_err=0.
2. Single parity error, recovered:
   - Stimulus: bad parity on word 3 first read, good on re-read.
   - Response: word 3 read twice; shd_wdata = good data; load_done at cycle 53; load_err=0.
3. Persistent parity error:
   - Stimulus: word 5 parity always bad.
   - Response: 3 reads of addr 5; shd_wdata=0 at addr 5; load_err=1 sticky; remaining words load normally.
4. Trigger filtering:
   - Stimulus: second load_start edge after DONE; sw_reload pulse during busy.
   - Response: both ignored.
   - Stimulus: sw_reload in DONE.
   - Response: new load starts; load_done and load_err cleared.
5. Reset mid-load:
   - Stimulus: rst_n low during word 4.
   - Response: all outputs 0 immediately.
   - Stimulus: release reset, then load_start edge.
   - Response: full reload from addr 0.
6. Simultaneous triggers and clk_hold tracking:
   - Stimulus: auto edge and sw_reload in the same cycle.
   - Response: exactly one load runs; clk_hold equals load_busy in every cycle.
